// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset main controller: FETCH/DECODE/EXEC/MEM/WB sequencer
// with combinational datapath controls and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             ir_wr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_wr,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // State is kept as a raw 3-bit register so encodings 5-7 stay observable
  // and recoverable rather than being hidden behind the enum type.
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_next;
  logic             w_retire;

  logic w_is_r, w_is_jr, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_is_jal;
  logic w_is_addi, w_legal;

  assign w_is_r    = (op == OP_RTYPE);
  assign w_is_jr   = w_is_r && (funct == FN_JR);
  assign w_is_lw   = (op == OP_LW);
  assign w_is_sw   = (op == OP_SW);
  assign w_is_beq  = (op == OP_BEQ);
  assign w_is_j    = (op == OP_J);
  assign w_is_jal  = (op == OP_JAL);
  assign w_is_addi = (op == OP_ADDI);
  assign w_legal   = w_is_r | w_is_lw | w_is_sw | w_is_beq | w_is_j |
                     w_is_jal | w_is_addi;

  always_comb begin
    pc_wr      = 1'b0;
    pc_src     = 2'b00;
    ir_wr      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    reg_wr     = 1'b0;
    illegal    = 1'b0;
    w_retire   = 1'b0;
    w_next     = S_FETCH;
    case (r_state)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr  = 1'b1;
          pc_wr  = 1'b1;
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_is_j || w_is_jal) begin
          pc_wr    = 1'b1;
          pc_src   = 2'b10;
          w_retire = 1'b1;
          if (w_is_jal) begin
            reg_wr     = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end else if (!w_legal) begin
          illegal = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_jr) begin
          pc_wr    = 1'b1;
          pc_src   = 2'b11;
          w_retire = 1'b1;
        end else if (w_is_r) begin
          alu_op = 2'b10;
          w_next = S_WB;
        end else if (w_is_addi) begin
          alu_src = 1'b1;
          w_next  = S_WB;
        end else if (w_is_lw || w_is_sw) begin
          alu_src = 1'b1;
          w_next  = S_MEM;
        end else if (w_is_beq) begin
          alu_op   = 2'b01;
          pc_src   = 2'b01;
          pc_wr    = zero;
          w_retire = 1'b1;
        end
      end
      S_MEM: begin
        // Strobes are mutually exclusive by construction: one opcode arm each.
        if (w_is_lw) begin
          mem_rd = 1'b1;
          w_next = mem_ready ? S_WB : S_MEM;
        end else if (w_is_sw) begin
          mem_wr   = 1'b1;
          w_retire = mem_ready;
          w_next   = mem_ready ? S_FETCH : S_MEM;
        end
      end
      S_WB: begin
        if (w_is_r || w_is_addi || w_is_lw) begin
          reg_wr   = 1'b1;
          w_retire = 1'b1;
          if (w_is_r)  reg_dst    = 2'b01;
          if (w_is_lw) mem_to_reg = 2'b01;
        end
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign state     = r_state;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (CNT_W=4): driver pushes hand-computed
// per-cycle output vectors, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_JR   = 6'b001000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_wr, ir_wr, mem_rd, mem_wr, alu_src, reg_wr, illegal;
  logic [1:0] pc_src, alu_op, reg_dst, mem_to_reg;
  logic [2:0] state;
  logic [3:0] instr_cnt;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_src(alu_src), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr),
    .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Vector layout: {state, pc_wr, pc_src, ir_wr, mem_rd, mem_wr, alu_src,
  //                 alu_op, reg_dst, mem_to_reg, reg_wr, illegal, instr_cnt}
  logic [21:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad = 0;

  function automatic logic [21:0] mk(
    input logic [2:0] st, input logic pw, input logic [1:0] ps,
    input logic irw, input logic mr, input logic mw, input logic as,
    input logic [1:0] ao, input logic [1:0] rd, input logic [1:0] m2r,
    input logic rw, input logic il, input logic [3:0] cnt);
    return {st, pw, ps, irw, mr, mw, as, ao, rd, m2r, rw, il, cnt};
  endfunction

  function automatic logic [21:0] e_fetch(input logic rdy, input logic [3:0] c);
    return mk(3'd0, rdy, 2'b00, rdy, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, c);
  endfunction

  function automatic logic [21:0] e_dec(input logic [3:0] c);
    return mk(3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, c);
  endfunction

  function automatic logic [21:0] e_jump(input logic jal, input logic [3:0] c);
    return mk(3'd1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
              jal ? 2'b10 : 2'b00, jal ? 2'b10 : 2'b00, jal, 1'b0, c);
  endfunction

  function automatic logic [21:0] e_ill(input logic [3:0] c);
    return mk(3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, c);
  endfunction

  function automatic logic [21:0] e_exec(input logic as, input logic [1:0] ao,
                                         input logic pw, input logic [1:0] ps,
                                         input logic [3:0] c);
    return mk(3'd2, pw, ps, 1'b0, 1'b0, 1'b0, as, ao, 2'b00, 2'b00, 1'b0, 1'b0, c);
  endfunction

  function automatic logic [21:0] e_mem(input logic rd, input logic wr, input logic [3:0] c);
    return mk(3'd3, 1'b0, 2'b00, 1'b0, rd, wr, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, c);
  endfunction

  function automatic logic [21:0] e_wb(input logic [1:0] rd, input logic [1:0] m2r,
                                       input logic [3:0] c);
    return mk(3'd4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, rd, m2r, 1'b1, 1'b0, c);
  endfunction

  // One clock cycle: inputs change just after the rising edge, so the pushed
  // vector describes the outputs seen for the rest of that cycle.
  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic mr, input logic chk,
                     input logic [21:0] e, input string tag);
    @(posedge clk);
    #1;
    rst       = r;
    op        = o;
    funct     = f;
    zero      = z;
    mem_ready = mr;
    if (chk) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  always @(negedge clk) begin
    logic [21:0] act, e;
    string       t;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      act = {state, pc_wr, pc_src, ir_wr, mem_rd, mem_wr, alu_src, alu_op,
             reg_dst, mem_to_reg, reg_wr, illegal, instr_cnt};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", t, act, e);
      end
    end
  end

  initial begin
    cyc(1'b1, OP_R, 6'd0, 1'b0, 1'b0, 1'b0, '0, "");
    cyc(1'b1, OP_R, 6'd0, 1'b0, 1'b0, 1'b0, '0, "");

    // lw, no memory stalls
    cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 4'd0), "lw_fetch");
    cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_dec(4'd0), "lw_decode");
    cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_exec(1'b1, 2'b00, 1'b0, 2'b00, 4'd0), "lw_exec");
    cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_mem(1'b1, 1'b0, 4'd0), "lw_mem");
    cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_wb(2'b00, 2'b01, 4'd0), "lw_wb");

    // FETCH stalled three cycles, then a j
    for (int i = 0; i < 3; i++)
      cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b0, 4'd1), "fetch_wait");
    cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 4'd1), "fetch_done");
    cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b1, 1'b1, e_jump(1'b0, 4'd1), "j_decode");

    // R-type add
    cyc(1'b0, OP_R, FN_ADD, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 4'd2), "r_fetch");
    cyc(1'b0, OP_R, FN_ADD, 1'b0, 1'b1, 1'b1, e_dec(4'd2), "r_decode");
    cyc(1'b0, OP_R, FN_ADD, 1'b0, 1'b1, 1'b1, e_exec(1'b0, 2'b10, 1'b0, 2'b00, 4'd2), "r_exec");
    cyc(1'b0, OP_R, FN_ADD, 1'b0, 1'b1, 1'b1, e_wb(2'b01, 2'b00, 4'd2), "r_wb");

    // jr
    cyc(1'b0, OP_R, FN_JR, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 4'd3), "jr_fetch");
    cyc(1'b0, OP_R, FN_JR, 1'b0, 1'b1, 1'b1, e_dec(4'd3), "jr_decode");
    cyc(1'b0, OP_R, FN_JR, 1'b0, 1'b1, 1'b1, e_exec(1'b0, 2'b00, 1'b1, 2'b11, 4'd3), "jr_exec");

    // jal: two-cycle instruction
    cyc(1'b0, OP_JAL, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 4'd4), "jal_fetch");
    cyc(1'b0, OP_JAL, 6'd0, 1'b0, 1'b1, 1'b1, e_jump(1'b1, 4'd4), "jal_decode");

    // illegal opcode: single-cycle pulse, count unchanged
    cyc(1'b0, OP_BAD, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 4'd5), "ill_fetch");
    cyc(1'b0, OP_BAD, 6'd0, 1'b0, 1'b1, 1'b1, e_ill(4'd5), "ill_decode");

    // sw with two memory wait cycles
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 4'd5), "ill_after");
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 1'b1, e_dec(4'd5), "sw_decode");
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_exec(1'b1, 2'b00, 1'b0, 2'b00, 4'd5), "sw_exec");
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_mem(1'b0, 1'b1, 4'd5), "sw_wait1");
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_mem(1'b0, 1'b1, 4'd5), "sw_wait2");
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 1'b1, e_mem(1'b0, 1'b1, 4'd5), "sw_done");
    cyc(1'b0, OP_BEQ, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b0, 4'd6), "sw_after");

    // beq not taken, then taken, from a fresh reset
    cyc(1'b1, OP_BEQ, 6'd0, 1'b0, 1'b0, 1'b0, '0, "");
    cyc(1'b0, OP_BEQ, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 4'd0), "rst_fetch");
    cyc(1'b0, OP_BEQ, 6'd0, 1'b0, 1'b1, 1'b1, e_dec(4'd0), "beq0_decode");
    cyc(1'b0, OP_BEQ, 6'd0, 1'b0, 1'b1, 1'b1, e_exec(1'b0, 2'b01, 1'b0, 2'b01, 4'd0), "beq0_exec");
    cyc(1'b0, OP_BEQ, 6'd0, 1'b1, 1'b1, 1'b1, e_fetch(1'b1, 4'd1), "beq1_fetch");
    cyc(1'b0, OP_BEQ, 6'd0, 1'b1, 1'b1, 1'b1, e_dec(4'd1), "beq1_decode");
    cyc(1'b0, OP_BEQ, 6'd0, 1'b1, 1'b1, 1'b1, e_exec(1'b0, 2'b01, 1'b1, 2'b01, 4'd1), "beq1_exec");
    cyc(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b0, 4'd2), "beq_count");

    // 16 addi from reset: 4-bit counter wraps back to 0
    cyc(1'b1, OP_ADDI, 6'd0, 1'b0, 1'b0, 1'b0, '0, "");
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 4'(i)), "addi_fetch");
      cyc(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, 1'b1, e_dec(4'(i)), "addi_decode");
      cyc(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, 1'b1, e_exec(1'b1, 2'b00, 1'b0, 2'b00, 4'(i)), "addi_exec");
      cyc(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, 1'b1, e_wb(2'b00, 2'b00, 4'(i)), "addi_wb");
    end

    // sw abandoned by reset during its MEM wait; reset wins over mem_ready
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 4'd0), "wrap_fetch");
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 1'b1, e_dec(4'd0), "sw2_decode");
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_exec(1'b1, 2'b00, 1'b0, 2'b00, 4'd0), "sw2_exec");
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_mem(1'b0, 1'b1, 4'd0), "sw2_wait");
    cyc(1'b1, OP_SW, 6'd0, 1'b0, 1'b1, 1'b0, '0, "");
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b0, 4'd0), "mem_rst");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
